// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: controller states,
// default operand width and the iteration-counter width derivation.
package div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } state_t;

    localparam int DEFAULT_N = 16;

    // The counter must hold the value N itself, hence one bit beyond clog2.
    function automatic int cw_of(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/div_datapath.sv
// Datapath of the sequential divider: operand capture, sign/magnitude
// conversion, restoring shift-and-subtract on magnitudes, iteration counter
// and the final sign correction into the registered results.
module div_datapath
    import div_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int CW = cw_of(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         capture,
    input  logic         load,
    input  logic         shift,
    input  logic         decr,
    input  logic         fix,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         dbz,
    output logic         ovf,
    output logic         count_zero,
    output logic         divisor_zero
);

    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0]  dvd_q, dvd_d, dvs_q, dvs_d;
    logic [N-1:0]  q_q, q_d, m_q, m_d;
    logic [N-1:0]  quo_q, quo_d, rem_q, rem_d;
    logic [N:0]    a_q, a_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sq_q, sq_d, sr_q, sr_d, dbz_q, dbz_d, ovf_q, ovf_d;
    logic [N+1:0]  shifted, trial;

    // Two's-complement magnitude; the most negative value maps to 2^(N-1),
    // which still fits the N-bit unsigned result.
    function automatic logic [N-1:0] mag(input logic [N-1:0] x);
        return x[N-1] ? -x : x;
    endfunction

    // Next-state computation for every datapath register, driven by strobes.
    always_comb begin
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        q_d   = q_q;
        m_d   = m_q;
        a_d   = a_q;
        cnt_d = cnt_q;
        sq_d  = sq_q;
        sr_d  = sr_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dbz_d = dbz_q;
        ovf_d = ovf_q;

        // A is kept one bit wider than needed; its top bit is always zero,
        // so folding it into the trial subtraction costs nothing.
        shifted = {a_q, q_q[N-1]};
        trial   = shifted - {2'b00, m_q};

        if (capture) begin
            dvd_d = dividend;
            dvs_d = divisor;
            dbz_d = 1'b0;
            ovf_d = 1'b0;
        end

        if (load) begin
            sq_d  = dvd_q[N-1] ^ dvs_q[N-1];
            sr_d  = dvd_q[N-1];
            q_d   = mag(dvd_q);
            m_d   = mag(dvs_q);
            a_d   = '0;
            cnt_d = CW'(N);
        end

        if (shift) begin
            if (!trial[N+1]) begin
                a_d = trial[N:0];
                q_d = {q_q[N-2:0], 1'b1};
            end else begin
                a_d = shifted[N:0];
                q_d = {q_q[N-2:0], 1'b0};
            end
        end

        if (decr) begin
            cnt_d = cnt_q - CW'(1);
        end

        if (fix) begin
            if (dvs_q == '0) begin
                quo_d = '1;
                rem_d = dvd_q;
                dbz_d = 1'b1;
            end else begin
                // Most-negative / -1 wraps naturally to -2^(N-1); only flag it.
                quo_d = sq_q ? -q_q : q_q;
                rem_d = sr_q ? -a_q[N-1:0] : a_q[N-1:0];
                ovf_d = (dvd_q == MOST_NEG) && (dvs_q == '1);
            end
        end
    end

    // Datapath register bank with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q <= '0;
            dvs_q <= '0;
            q_q   <= '0;
            m_q   <= '0;
            a_q   <= '0;
            cnt_q <= '0;
            sq_q  <= 1'b0;
            sr_q  <= 1'b0;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            q_q   <= q_d;
            m_q   <= m_d;
            a_q   <= a_d;
            cnt_q <= cnt_d;
            sq_q  <= sq_d;
            sr_q  <= sr_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dbz_q <= dbz_d;
            ovf_q <= ovf_d;
        end
    end

    assign quotient     = quo_q;
    assign remainder    = rem_q;
    assign dbz          = dbz_q;
    assign ovf          = ovf_q;
    // True during the iteration whose decrement brings the count to zero.
    assign count_zero   = (cnt_q == CW'(1));
    assign divisor_zero = (dvs_q == '0);

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider: controller FSM sequencing the div_datapath
// through LOAD, N restoring iterations and FIX, with a start/done handshake.
module seq_divider
    import div_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int CW = cw_of(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         dbz,
    output logic         ovf
);

    state_t state_q, state_d;
    logic   busy_q, busy_d, done_q, done_d;
    logic   capture, load, shift, decr, fix;
    logic   count_zero, divisor_zero;

    div_datapath #(
        .N  (N),
        .CW (CW)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .capture      (capture),
        .load         (load),
        .shift        (shift),
        .decr         (decr),
        .fix          (fix),
        .dividend     (dividend),
        .divisor      (divisor),
        .quotient     (quotient),
        .remainder    (remainder),
        .dbz          (dbz),
        .ovf          (ovf),
        .count_zero   (count_zero),
        .divisor_zero (divisor_zero)
    );

    // Next state and datapath strobes; busy/done are registered from the next state.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        decr    = 1'b0;
        fix     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load    = 1'b1;
                state_d = divisor_zero ? ST_FIX : ST_ITER;
            end
            ST_ITER: begin
                shift = 1'b1;
                decr  = 1'b1;
                if (count_zero) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                fix     = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_LOAD) || (state_d == ST_ITER) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    // Controller state and handshake flags with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random
// operands compared against an integer-arithmetic reference model.
module tb_seq_divider;

    localparam int N = 16;
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         dbz;
    logic         ovf;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed arithmetic (truncating division, remainder
    // takes the dividend's sign) plus the two documented special cases.
    task automatic ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                           output logic [N-1:0] q, output logic [N-1:0] r,
                           output logic z, output logic v);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z = 1'b0;
        v = 1'b0;
        if (sb == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (sa == -(longint'(1) << (N - 1)) && sb == -1) begin
            q = MOST_NEG;
            r = '0;
            v = 1'b1;
        end else begin
            q = N'(sa / sb);
            r = N'(sa % sb);
        end
    endtask

    // One full transaction; optionally pulses a second start (9 / 9) at
    // cycle poke_cyc, which must be ignored while the divider is busy.
    task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b, input int poke_cyc);
        logic [N-1:0] eq, er;
        logic         ez, ev;
        int           cyc;
        int           busy_err;
        int           exp_lat;
        ref_div(a, b, eq, er, ez, ev);
        exp_lat = (b == '0) ? 3 : N + 3;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        busy_err = 0;
        while (!done && cyc < 60) begin
            if (busy !== 1'b1) busy_err++;
            @(negedge clk);
            cyc++;
            start = (cyc == poke_cyc);
            if (start) begin
                dividend = N'(9);
                divisor  = N'(9);
            end
        end
        start = 1'b0;
        $display("[TB] %0d / %0d -> q=%0d r=%0d dbz=%0b ovf=%0b latency=%0d",
                 $signed(a), $signed(b), $signed(quotient), $signed(remainder), dbz, ovf, cyc);
        check("latency", cyc, exp_lat);
        check("busy_during", busy_err, 0);
        check("busy_at_done", busy, 0);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("dbz", dbz, ez);
        check("ovf", ovf, ev);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_after", busy, 0);
    endtask

    initial begin
        int gap;
        int t;
        logic saw_done;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", dbz, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;

        // Directed cases from the sign/edge table.
        do_div(N'(100), N'(7), 0);
        do_div(N'(-100), N'(7), 0);
        do_div(N'(100), N'(-7), 0);
        do_div(N'(-100), N'(-7), 0);
        do_div(N'(1234), N'(0), 0);
        do_div(MOST_NEG, N'(-1), 0);
        do_div(MOST_NEG, N'(1), 0);
        do_div(N'(50), N'(3), 5);
        do_div(N'(9), N'(9), 0);

        // Reset in the middle of 30000 / 7.
        @(negedge clk);
        start    = 1'b1;
        dividend = N'(30000);
        divisor  = N'(7);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 0);
        rst = 1'b0;
        do_div(N'(30000), N'(7), 0);

        // start held high: re-accepted in the IDLE cycle after DONE.
        @(negedge clk);
        start    = 1'b1;
        dividend = N'(100);
        divisor  = N'(7);
        t = 0;
        while (!done && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("hold_first_done", done, 1);
        gap = 0;
        @(negedge clk);
        gap = 1;
        while (!done && gap < 60) begin
            @(negedge clk);
            gap++;
        end
        start = 1'b0;
        $display("[TB] start held: done pulses %0d cycles apart, q=%0d", gap, $signed(quotient));
        check("hold_gap", gap, N + 4);
        check("hold_quotient", quotient, N'(14));
        @(negedge clk);

        // Random operands with a bias toward the special cases.
        for (int i = 0; i < 150; i++) begin
            logic [N-1:0] a, b;
            int sel;
            sel = $urandom_range(0, 9);
            a = N'($urandom);
            b = N'($urandom);
            case (sel)
                0: b = '0;
                1: begin
                    a = MOST_NEG;
                    b = ($urandom_range(0, 1) == 1) ? N'(-1) : N'(1);
                end
                2: b = N'($urandom_range(1, 15));
                3: b = -N'($urandom_range(1, 15));
                default: ;
            endcase
            do_div(a, b, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
